// File: rtl/mdiv_pool.sv
// mdiv_pool: pool of NUNITS iterative restoring dividers (DIV/DIVU/REM/REMU,
// plus word forms) with opid-based redirect kill and round-robin delivery.
// Ports: clk, rst (sync, active-high); req_* request handshake; redir_*
// flush of younger ops; resp_* result handshake; busy = per-unit not-IDLE.
module mdiv_pool #(
    parameter int XLEN   = 64,
    parameter int NUNITS = 2,
    parameter int OPSZ   = 32,
    parameter int EARLY  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_opid,
    input  logic [2:0]        req_op,
    input  logic [XLEN-1:0]   req_a,
    input  logic [XLEN-1:0]   req_b,
    input  logic              redir_valid,
    input  logic [15:0]       redir_opid,
    input  logic [15:0]       redir_topid,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [15:0]       resp_opid,
    output logic [XLEN-1:0]   resp_val,
    output logic [NUNITS-1:0] busy
);

    localparam int K  = $clog2(OPSZ);
    localparam int UW = (NUNITS > 1) ? $clog2(NUNITS) : 1;
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      st     [NUNITS];
    logic            first  [NUNITS];
    logic            sq     [NUNITS];
    logic            sr     [NUNITS];
    logic [15:0]     opid_r [NUNITS];
    logic [2:0]      op_r   [NUNITS];
    logic [XLEN-1:0] a_r    [NUNITS];
    logic [XLEN-1:0] b_r    [NUNITS];
    logic [XLEN-1:0] dvd_r  [NUNITS];
    logic [XLEN-1:0] rem_r  [NUNITS];
    logic [XLEN-1:0] res_r  [NUNITS];
    logic [CW-1:0]   cnt_r  [NUNITS];
    logic [XLEN:0]   trial  [NUNITS];
    logic            ge     [NUNITS];

    logic [UW-1:0]     ptr;
    logic [UW-1:0]     lidx;
    logic              lock;
    logic [NUNITS-1:0] idle;
    logic [NUNITS-1:0] kill;
    logic [NUNITS-1:0] cand;
    logic [UW-1:0]     acc_idx;
    logic [UW-1:0]     sel;
    logic              acc;
    logic              acc_kill;
    logic              deliver;
    logic              unused_ok;

    assign unused_ok = ^{redir_opid[14:K], redir_topid[15:K]};

    function automatic logic [XLEN-1:0] sx32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = v[31];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zx32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = 1'b0;
        return r;
    endfunction

    function automatic logic is_word(input logic [2:0] op);
        return (XLEN == 64) && op[2];
    endfunction

    function automatic logic msb(input logic [XLEN-1:0] v, input logic w);
        return w ? v[31] : v[XLEN-1];
    endfunction

    // Magnitude at width W, zero-extended to XLEN.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                            input logic w, input logic sg);
        logic [XLEN-1:0] t;
        t = w ? sx32(v) : v;
        if (sg && t[XLEN-1]) t = -t;
        return w ? zx32(t) : t;
    endfunction

    function automatic logic div_zero(input logic [XLEN-1:0] b,
                                      input logic [2:0] op);
        return is_word(op) ? (b[31:0] == 32'd0) : (b == '0);
    endfunction

    function automatic logic ovf(input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b,
                                 input logic [2:0] op);
        logic m;
        if (is_word(op))
            m = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        else
            m = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        return !op[0] && m;
    endfunction

    function automatic logic [XLEN-1:0] spec_res(input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b,
                                                 input logic [2:0] op);
        logic [XLEN-1:0] ax;
        ax = is_word(op) ? sx32(a) : a;
        if (div_zero(b, op)) return op[1] ? ax : '1;
        return op[1] ? '0 : ax;
    endfunction

    // Dividend magnitude left-aligned so the MSB of width W sits at XLEN-1.
    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a,
                                              input logic [2:0] op);
        logic [XLEN-1:0] dv;
        dv = mag(a, is_word(op), !op[0]);
        if (is_word(op)) dv = dv << (XLEN - 32);
        return dv;
    endfunction

    // Iterations skipped above the leading one; always leaves at least one.
    function automatic logic [CW-1:0] skip(input logic [XLEN-1:0] dv,
                                           input logic [2:0] op);
        logic [CW-1:0] n;
        logic [CW-1:0] lim;
        if (EARLY == 0) return '0;
        n = CW'(XLEN);
        for (int i = 0; i < XLEN; i++) if (dv[i]) n = CW'(XLEN - 1 - i);
        lim = is_word(op) ? CW'(31) : CW'(XLEN - 1);
        return (n > lim) ? lim : n;
    endfunction

    function automatic logic [CW-1:0] width(input logic [2:0] op);
        return is_word(op) ? CW'(32) : CW'(XLEN);
    endfunction

    function automatic logic [XLEN-1:0] fix(input logic [XLEN-1:0] q,
                                            input logic [XLEN-1:0] r,
                                            input logic nq, input logic nr,
                                            input logic [2:0] op);
        logic [XLEN-1:0] v;
        v = op[1] ? (nr ? -r : r) : (nq ? -q : q);
        return is_word(op) ? sx32(v) : v;
    endfunction

    function automatic logic younger(input logic [15:0] x,
                                     input logic [15:0] ro,
                                     input logic [15:0] to);
        logic [K-1:0] dx;
        logic [K-1:0] dr;
        dx = x[K-1:0] - to[K-1:0];
        dr = ro[K-1:0] - to[K-1:0];
        return ro[15] && x[15] && ({1'b0, dx} >= ({1'b0, dr} + 1'b1));
    endfunction

    always_comb begin
        for (int u = 0; u < NUNITS; u++) begin
            idle[u]  = (st[u] == S_IDLE);
            busy[u]  = !idle[u];
            kill[u]  = redir_valid && !idle[u]
                     && younger(opid_r[u], redir_opid, redir_topid);
            cand[u]  = (st[u] == S_DONE) && !kill[u];
            trial[u] = {rem_r[u], dvd_r[u][XLEN-1]};
            ge[u]    = trial[u] >= {1'b0, b_r[u]};
        end
    end

    assign req_ready = |idle;
    assign acc       = req_valid && req_ready && req_opid[15];
    assign acc_kill  = redir_valid
                     && younger(req_opid, redir_opid, redir_topid);

    always_comb begin
        acc_idx = '0;
        for (int i = NUNITS - 1; i >= 0; i--)
            if (idle[i]) acc_idx = UW'(i);
    end

    // A stalled presentation is locked so its data stays stable.
    always_comb begin
        sel        = '0;
        resp_valid = 1'b0;
        if (lock && cand[lidx]) begin
            sel        = lidx;
            resp_valid = 1'b1;
        end else begin
            for (int i = 1; i <= NUNITS; i++) begin
                if (!resp_valid && cand[(int'(ptr) + i) % NUNITS]) begin
                    sel        = UW'((int'(ptr) + i) % NUNITS);
                    resp_valid = 1'b1;
                end
            end
        end
    end

    assign deliver   = resp_valid && resp_ready;
    assign resp_opid = resp_valid ? opid_r[sel] : '0;
    assign resp_val  = resp_valid ? res_r[sel] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= '0;
            lidx <= '0;
            lock <= 1'b0;
            for (int u = 0; u < NUNITS; u++) begin
                st[u]     <= S_IDLE;
                first[u]  <= 1'b0;
                sq[u]     <= 1'b0;
                sr[u]     <= 1'b0;
                opid_r[u] <= '0;
                op_r[u]   <= '0;
                a_r[u]    <= '0;
                b_r[u]    <= '0;
                dvd_r[u]  <= '0;
                rem_r[u]  <= '0;
                res_r[u]  <= '0;
                cnt_r[u]  <= '0;
            end
        end else begin
            lock <= resp_valid && !resp_ready;
            lidx <= sel;
            if (deliver) ptr <= sel;
            for (int u = 0; u < NUNITS; u++) begin
                if (kill[u] || (deliver && sel == UW'(u))) begin
                    st[u] <= S_IDLE;
                end else begin
                    case (st[u])
                        S_IDLE: begin
                            if (acc && !acc_kill && acc_idx == UW'(u)) begin
                                st[u]     <= S_CALC;
                                first[u]  <= 1'b1;
                                opid_r[u] <= req_opid;
                                op_r[u]   <= req_op;
                                a_r[u]    <= req_a;
                                b_r[u]    <= req_b;
                            end
                        end
                        S_CALC: begin
                            if (first[u]) begin
                                // Setup cycle: special cases finish here.
                                if (div_zero(b_r[u], op_r[u])
                                    || ovf(a_r[u], b_r[u], op_r[u])) begin
                                    res_r[u] <= spec_res(a_r[u], b_r[u],
                                                         op_r[u]);
                                    st[u]    <= S_DONE;
                                end else begin
                                    dvd_r[u] <= align(a_r[u], op_r[u])
                                        << skip(align(a_r[u], op_r[u]),
                                                op_r[u]);
                                    cnt_r[u] <= width(op_r[u])
                                        - skip(align(a_r[u], op_r[u]),
                                               op_r[u]);
                                    rem_r[u] <= '0;
                                    b_r[u]   <= mag(b_r[u], is_word(op_r[u]),
                                                    !op_r[u][0]);
                                    sq[u]    <= !op_r[u][0]
                                        && (msb(a_r[u], is_word(op_r[u]))
                                        ^ msb(b_r[u], is_word(op_r[u])));
                                    sr[u]    <= !op_r[u][0]
                                        && msb(a_r[u], is_word(op_r[u]));
                                    first[u] <= 1'b0;
                                end
                            end else begin
                                // Quotient bits shift into the dividend LSBs.
                                if (ge[u])
                                    rem_r[u] <= XLEN'(trial[u]
                                                - {1'b0, b_r[u]});
                                else
                                    rem_r[u] <= trial[u][XLEN-1:0];
                                dvd_r[u] <= {dvd_r[u][XLEN-2:0], ge[u]};
                                cnt_r[u] <= cnt_r[u] - 1'b1;
                                if (cnt_r[u] == CW'(1)) st[u] <= S_FIX;
                            end
                        end
                        S_FIX: begin
                            res_r[u] <= fix(dvd_r[u], rem_r[u], sq[u], sr[u],
                                            op_r[u]);
                            st[u]    <= S_DONE;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mdiv_pool.sv
// tb_mdiv_pool: directed bench for mdiv_pool (XLEN=64, NUNITS=2, EARLY=0)
// with an expected-result queue checked at every response handshake.
module tb_mdiv_pool;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_opid;
    logic [2:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        redir_valid;
    logic [15:0] redir_opid;
    logic [15:0] redir_topid;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_opid;
    logic [63:0] resp_val;
    logic [1:0]  busy;

    typedef struct packed {
        logic [15:0] id;
        logic [63:0] v;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;

    mdiv_pool #(.XLEN(64), .NUNITS(2), .OPSZ(32), .EARLY(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opid(req_opid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .redir_valid(redir_valid), .redir_opid(redir_opid),
        .redir_topid(redir_topid),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_opid(resp_opid), .resp_val(resp_val),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are stable from posedge+1, so a handshake seen here completes
    // at the next posedge.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sbq.size() == 0) begin
                chk("spurious_resp", {48'd0, resp_opid}, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("resp_opid", {48'd0, resp_opid}, {48'd0, mon_e.id});
                chk("resp_val", resp_val, mon_e.v);
            end
        end
    end

    task automatic issue(input logic [15:0] id, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic push, input logic [63:0] ev);
        req_valid = 1'b1;
        req_opid  = id;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        if (push) sbq.push_back('{id: id, v: ev});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        chk("drain", 64'(sbq.size()), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] id,
                          input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] ev,
                          input int lat);
        int n = 0;
        issue(id, op, a, b, 1'b1, ev);
        while (!resp_valid && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'(lat));
        drain();
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_opid    = '0;
        req_op      = '0;
        req_a       = '0;
        req_b       = '0;
        redir_valid = 1'b0;
        redir_opid  = '0;
        redir_topid = '0;
        resp_ready  = 1'b1;
        tick();
        tick();
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_opid", {48'd0, resp_opid}, 64'd0);
        chk("rst_resp_val", resp_val, 64'd0);
        chk("rst_busy", {62'd0, busy}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        rst = 1'b0;
        tick();

        run_op("lat_div", 16'h8001, 3'b000, -64'sd7, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("lat_rem", 16'h8002, 3'b010, -64'sd7, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("lat_divw_ovf", 16'h8003, 3'b100, 64'h8000_0000,
               64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("lat_remw_ovf", 16'h8004, 3'b110, 64'h8000_0000,
               64'hFFFF_FFFF, 64'd0, 1);
        run_op("lat_divu_z", 16'h8005, 3'b001, 64'd5, 64'd0,
               64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("lat_remuw_z", 16'h8006, 3'b111, 64'h1_8000_0000, 64'd0,
               64'hFFFF_FFFF_8000_0000, 1);
        run_op("lat_divuw", 16'h8007, 3'b101, 64'hFFFF_FFFE, 64'd1,
               64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op("lat_div_neg", 16'h8008, 3'b000, -64'sd100, -64'sd7,
               64'd14, 66);
        run_op("lat_rem_neg", 16'h8009, 3'b010, -64'sd100, 64'd7,
               -64'sd2, 66);

        // Back-to-back with a stalled consumer.
        resp_ready = 1'b0;
        issue(16'h8001, 3'b001, 64'd100, 64'd7, 1'b1, 64'd100 / 64'd7);
        issue(16'h8002, 3'b001, 64'd1000, 64'd3, 1'b1, 64'd1000 / 64'd3);
        chk("b2b_ready_low", {63'd0, req_ready}, 64'd0);
        req_valid = 1'b1;
        req_opid  = 16'h8003;
        req_op    = 3'b001;
        req_a     = 64'd77;
        req_b     = 64'd5;
        sbq.push_back('{id: 16'h8003, v: 64'd77 / 64'd5});
        begin
            int n = 0;
            while (!resp_valid && n < 200) begin
                tick();
                n++;
            end
            chk("b2b_first_lat", 64'(n), 64'd65);
        end
        for (int i = 0; i < 10; i++) begin
            chk("b2b_stall_opid", {48'd0, resp_opid}, 64'h8001);
            chk("b2b_stall_val", resp_val, 64'd14);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("b2b_busy_after_d0", {62'd0, busy}, 64'b10);
        chk("b2b_ready_after_d0", {63'd0, req_ready}, 64'd1);
        tick();
        req_valid = 1'b0;
        chk("b2b_busy_c_in_u0", {62'd0, busy}, 64'b01);
        drain();

        // Redirect kills the younger of two in-flight ops.
        issue(16'h8003, 3'b001, 64'd50, 64'd7, 1'b1, 64'd7);
        issue(16'h8005, 3'b001, 64'd9, 64'd2, 1'b0, 64'd0);
        redir_valid = 1'b1;
        redir_opid  = 16'h8004;
        redir_topid = 16'h8001;
        tick();
        redir_valid = 1'b0;
        chk("flush_busy", {62'd0, busy}, 64'b01);
        drain();

        // An accept made younger by a same-cycle redirect is discarded.
        req_valid   = 1'b1;
        req_opid    = 16'h8006;
        req_op      = 3'b001;
        req_a       = 64'd9;
        req_b       = 64'd3;
        redir_valid = 1'b1;
        tick();
        req_valid   = 1'b0;
        redir_valid = 1'b0;
        chk("acc_kill_busy", {62'd0, busy}, 64'd0);
        repeat (80) tick();

        // Reset mid-CALC discards everything.
        issue(16'h8007, 3'b001, 64'd1234, 64'd5, 1'b0, 64'd0);
        repeat (10) tick();
        chk("midcalc_busy_pre", {62'd0, busy}, 64'b01);
        rst = 1'b1;
        tick();
        chk("midcalc_busy", {62'd0, busy}, 64'd0);
        chk("midcalc_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("midcalc_req_ready", {63'd0, req_ready}, 64'd1);
        rst = 1'b0;
        repeat (80) tick();
        chk("final_queue", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
